// File: rtl/scr_wr_sched.sv
// Screen RAM write scheduler: host byte writes (through a small FIFO) and a
// block-fill engine share one RAM write port under round-robin arbitration.
module scr_wr_sched #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          host_wr_valid,
   output logic                          host_wr_ready,
   input  logic [ADDR_W-1:0]             host_wr_addr,
   input  logic [DATA_W-1:0]             host_wr_data,
   input  logic                          fill_start,
   input  logic [ADDR_W-1:0]             fill_base,
   input  logic [ADDR_W-1:0]             fill_count,
   input  logic [DATA_W-1:0]             fill_value,
   output logic                          fill_busy,
   output logic                          fill_done,
   input  logic                          ram_hold,
   output logic [ADDR_W-1:0]             ram_wraddress,
   output logic [DATA_W-1:0]             ram_data,
   output logic                          ram_wren,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(FIFO_DEPTH);
   localparam logic [LVL_W-1:0]  ONE_L    = LVL_W'(1);
   localparam logic [LVL_W-1:0]  ZERO_L   = LVL_W'(0);
   localparam logic [PTR_W-1:0]  ONE_P    = PTR_W'(1);
   localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ZERO_A   = ADDR_W'(0);
   localparam logic [DATA_W-1:0] ZERO_D   = DATA_W'(0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_DONE = 2'd2
   } fill_state_t;

   logic [ADDR_W-1:0] mem_addr_r [FIFO_DEPTH];
   logic [DATA_W-1:0] mem_data_r [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
   logic [LVL_W-1:0]  level_r, level_nxt_s;
   logic              ready_r;
   logic              push_s;

   fill_state_t       state_r, state_nxt_s;
   logic [ADDR_W-1:0] fill_addr_r, fill_rem_r;
   logic [DATA_W-1:0] fill_val_r;
   logic              fill_busy_r, fill_done_r;

   logic              host_req_s, fill_req_s;
   logic              grant_host_s, grant_fill_s;
   logic              last_fill_r;

   logic              ram_wren_r;
   logic [ADDR_W-1:0] ram_addr_r;
   logic [DATA_W-1:0] ram_data_r;

   // Pushes are refused whenever full, even if a pop frees a slot this cycle.
   assign push_s     = host_wr_valid & ready_r;
   assign host_req_s = (level_r != ZERO_L);
   assign fill_req_s = (state_r == ST_FILL);

   // Round-robin arbiter; a held cycle grants nothing and keeps last_fill_r.
   always_comb begin
      grant_host_s = 1'b0;
      grant_fill_s = 1'b0;
      if (ram_hold) begin
         grant_host_s = 1'b0;
         grant_fill_s = 1'b0;
      end else if (host_req_s && fill_req_s) begin
         grant_host_s = last_fill_r;
         grant_fill_s = ~last_fill_r;
      end else begin
         grant_host_s = host_req_s;
         grant_fill_s = fill_req_s;
      end
   end

   // Next FIFO occupancy.
   always_comb begin
      level_nxt_s = level_r;
      case ({push_s, grant_host_s})
         2'b10:   level_nxt_s = level_r + ONE_L;
         2'b01:   level_nxt_s = level_r - ONE_L;
         default: level_nxt_s = level_r;
      endcase
   end

   // FIFO storage (no reset needed: only read when occupancy says valid).
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_addr_r[wr_ptr_r] <= host_wr_addr;
         mem_data_r[wr_ptr_r] <= host_wr_data;
      end
   end

   // FIFO pointers, occupancy and registered ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         level_r  <= ZERO_L;
         ready_r  <= 1'b1;
      end else begin
         if (push_s)       wr_ptr_r <= wr_ptr_r + ONE_P;
         if (grant_host_s) rd_ptr_r <= rd_ptr_r + ONE_P;
         level_r <= level_nxt_s;
         ready_r <= (level_nxt_s != FULL_LVL);
      end
   end

   // Fill FSM next-state.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (fill_start) begin
               if (fill_count != ZERO_A) state_nxt_s = ST_FILL;
               else                      state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_FILL: begin
            if (grant_fill_s && (fill_rem_r == ONE_A)) state_nxt_s = ST_DONE;
            else                                         state_nxt_s = ST_FILL;
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Fill state register, walking address/remaining count and status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         fill_addr_r <= ZERO_A;
         fill_rem_r  <= ZERO_A;
         fill_val_r  <= ZERO_D;
         fill_busy_r <= 1'b0;
         fill_done_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         fill_busy_r <= (state_nxt_s == ST_FILL);
         fill_done_r <= (state_nxt_s == ST_DONE);
         if ((state_r == ST_IDLE) && fill_start) begin
            fill_addr_r <= fill_base;
            fill_rem_r  <= fill_count;
            fill_val_r  <= fill_value;
         end else if (grant_fill_s) begin
            fill_addr_r <= fill_addr_r + ONE_A;
            fill_rem_r  <= fill_rem_r - ONE_A;
         end
      end
   end

   // Last-grant memory; reset to fill so the host wins the first contention.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_fill_r <= 1'b1;
      end else if (grant_host_s) begin
         last_fill_r <= 1'b0;
      end else if (grant_fill_s) begin
         last_fill_r <= 1'b1;
      end
   end

   // RAM write port register; address/data hold when nothing is granted.
   always_ff @(posedge clk) begin
      if (rst) begin
         ram_wren_r <= 1'b0;
         ram_addr_r <= ZERO_A;
         ram_data_r <= ZERO_D;
      end else if (grant_host_s) begin
         ram_wren_r <= 1'b1;
         ram_addr_r <= mem_addr_r[rd_ptr_r];
         ram_data_r <= mem_data_r[rd_ptr_r];
      end else if (grant_fill_s) begin
         ram_wren_r <= 1'b1;
         ram_addr_r <= fill_addr_r;
         ram_data_r <= fill_val_r;
      end else begin
         ram_wren_r <= 1'b0;
      end
   end

   assign host_wr_ready = ready_r;
   assign fill_busy     = fill_busy_r;
   assign fill_done     = fill_done_r;
   assign ram_wren      = ram_wren_r;
   assign ram_wraddress = ram_addr_r;
   assign ram_data      = ram_data_r;
   assign fifo_level    = level_r;

endmodule

// File: tb/tb_scr_wr_sched.sv
// Bench for scr_wr_sched: directed scenarios plus random traffic, checked per
// cycle against a queue-based transaction model through a scoreboard queue.
module tb_scr_wr_sched;

   localparam int AW    = 16;
   localparam int DW    = 8;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          host_wr_valid = 1'b0;
   logic          host_wr_ready;
   logic [AW-1:0] host_wr_addr = '0;
   logic [DW-1:0] host_wr_data = '0;
   logic          fill_start = 1'b0;
   logic [AW-1:0] fill_base = '0;
   logic [AW-1:0] fill_count = '0;
   logic [DW-1:0] fill_value = '0;
   logic          fill_busy, fill_done;
   logic          ram_hold = 1'b0;
   logic [AW-1:0] ram_wraddress;
   logic [DW-1:0] ram_data;
   logic          ram_wren;
   logic [2:0]    fifo_level;

   always #5 clk = ~clk;

   scr_wr_sched #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
      .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
      .fill_start(fill_start), .fill_base(fill_base), .fill_count(fill_count),
      .fill_value(fill_value), .fill_busy(fill_busy), .fill_done(fill_done),
      .ram_hold(ram_hold), .ram_wraddress(ram_wraddress), .ram_data(ram_data),
      .ram_wren(ram_wren), .fifo_level(fifo_level)
   );

   typedef struct {
      bit            wren;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      bit            busy;
      bit            done;
      int            level;
      bit            ready;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model: pending host writes as a queue, fill as a job descriptor.
   logic [AW-1:0] mh_addr[$];
   logic [DW-1:0] mh_data[$];
   bit            mf_active = 1'b0;
   bit            mf_done = 1'b0;
   logic [AW-1:0] mf_addr = '0;
   int            mf_rem = 0;
   logic [DW-1:0] mf_val = '0;
   bit            m_last_fill = 1'b1;
   logic [AW-1:0] mo_addr = '0;
   logic [DW-1:0] mo_data = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
      end
   endtask

   task automatic model_step();
      exp_t e;
      bit   push, gh, gf, idle_pre, done_next;
      int   size_pre;
      e.wren = 1'b0;
      if (rst) begin
         mh_addr.delete();
         mh_data.delete();
         mf_active   = 1'b0;
         mf_done     = 1'b0;
         m_last_fill = 1'b1;
         mo_addr     = '0;
         mo_data     = '0;
      end else begin
         size_pre  = mh_addr.size();
         idle_pre  = !mf_active && !mf_done;
         push      = host_wr_valid && (size_pre < DEPTH);
         gh        = 1'b0;
         gf        = 1'b0;
         done_next = 1'b0;
         if (!ram_hold) begin
            // under contention the stream not served last goes first
            if (size_pre > 0 && mf_active) begin
               gh = m_last_fill;
               gf = !m_last_fill;
            end else begin
               gh = (size_pre > 0);
               gf = mf_active;
            end
         end
         if (gh) begin
            mo_addr     = mh_addr.pop_front();
            mo_data     = mh_data.pop_front();
            m_last_fill = 1'b0;
            e.wren      = 1'b1;
         end
         if (gf) begin
            mo_addr     = mf_addr;
            mo_data     = mf_val;
            mf_addr     = mf_addr + 16'd1;
            mf_rem      = mf_rem - 1;
            m_last_fill = 1'b1;
            e.wren      = 1'b1;
            if (mf_rem == 0) begin
               mf_active = 1'b0;
               done_next = 1'b1;
            end
         end
         if (idle_pre && fill_start) begin
            if (fill_count != 16'd0) begin
               mf_active = 1'b1;
               mf_addr   = fill_base;
               mf_rem    = int'(fill_count);
               mf_val    = fill_value;
            end else begin
               done_next = 1'b1;
            end
         end
         mf_done = done_next;
         if (push) begin
            mh_addr.push_back(host_wr_addr);
            mh_data.push_back(host_wr_data);
         end
      end
      e.addr  = mo_addr;
      e.data  = mo_data;
      e.busy  = mf_active;
      e.done  = mf_done;
      e.level = mh_addr.size();
      e.ready = (mh_addr.size() != DEPTH);
      exp_q.push_back(e);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   // Monitor: compare DUT outputs on the falling edge against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ram_wren",      32'(ram_wren),      32'(e.wren));
            chk("ram_wraddress", 32'(ram_wraddress), 32'(e.addr));
            chk("ram_data",      32'(ram_data),      32'(e.data));
            chk("fill_busy",     32'(fill_busy),     32'(e.busy));
            chk("fill_done",     32'(fill_done),     32'(e.done));
            chk("fifo_level",    32'(fifo_level),    32'(e.level));
            chk("host_wr_ready", 32'(host_wr_ready), 32'(e.ready));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Hold a host write until it is accepted (bounded).
   task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bit acc;
      int n;
      host_wr_valid = 1'b1;
      host_wr_addr  = a;
      host_wr_data  = d;
      n = 0;
      do begin
         acc = host_wr_ready;
         tick();
         n++;
      end while (!acc && n < 50);
      if (!acc) begin
         errors++;
         checks++;
         $display("FAIL host_accept_timeout at %0t: got not-accepted expected accepted", $time);
      end
      host_wr_valid = 1'b0;
   endtask

   task automatic start_fill(input logic [AW-1:0] b, input logic [AW-1:0] c, input logic [DW-1:0] v);
      fill_start = 1'b1;
      fill_base  = b;
      fill_count = c;
      fill_value = v;
      tick();
      fill_start = 1'b0;
   endtask

   initial begin
      idle(2);
      rst = 1'b0;

      // single host write
      host_write(16'h0123, 8'h41);
      idle(4);

      // fill FIFO under hold, then drain
      ram_hold = 1'b1;
      for (int i = 0; i < 4; i++) host_write(16'h0200 + 16'(i), 8'h10 + 8'(i));
      host_wr_valid = 1'b1;
      host_wr_addr  = 16'h0204;
      host_wr_data  = 8'h14;
      idle(3);
      ram_hold = 1'b0;
      host_write(16'h0204, 8'h14);
      host_write(16'h0205, 8'h15);
      idle(8);

      // plain fill
      start_fill(16'h0010, 16'd5, 8'h20);
      idle(8);

      // fill contending with host writes
      fill_start = 1'b1;
      fill_base  = 16'h0300;
      fill_count = 16'd3;
      fill_value = 8'h77;
      host_write(16'h0400, 8'hA0);
      fill_start = 1'b0;
      host_write(16'h0401, 8'hA1);
      host_write(16'h0402, 8'hA2);
      idle(8);

      // address wrap and zero-length fill
      start_fill(16'hFFFE, 16'd3, 8'h33);
      idle(6);
      start_fill(16'h1234, 16'd0, 8'h44);
      idle(4);

      // reset in the middle of a fill
      start_fill(16'h0100, 16'd6, 8'h55);
      idle(3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle(2);
      start_fill(16'h0500, 16'd2, 8'h66);
      idle(5);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         host_wr_valid = ($urandom % 2) == 0;
         host_wr_addr  = 16'($urandom);
         host_wr_data  = 8'($urandom);
         ram_hold      = ($urandom % 5) == 0;
         fill_start    = ($urandom % 12) == 0;
         fill_base     = (($urandom % 4) == 0) ? 16'hFFFC + 16'($urandom % 4) : 16'($urandom);
         fill_count    = 16'($urandom % 7);
         fill_value    = 8'($urandom);
         rst           = ($urandom % 400) == 0;
         tick();
      end
      rst           = 1'b0;
      host_wr_valid = 1'b0;
      fill_start    = 1'b0;
      ram_hold      = 1'b0;
      idle(20);
      @(negedge clk);
      #1;
      chk("scoreboard_drained", 32'(exp_q.size() <= 1), 32'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
